// File: rtl/i2s_pkg.sv
// Shared widths and FSM state types for the I2S receive capture path.
package i2s_pkg;
    localparam int SAMPLE_W         = 16;
    localparam int SLOT_W           = 32;
    localparam int SAMPLES_PER_WORD = 8;
    localparam int WORD_W           = 128;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE} cap_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_ADV} wr_state_t;
endpackage

// File: rtl/i2s_rx_fifo.sv
// Single-clock register FIFO between the word packer and the SDRAM writer.
// A push while full is accepted only if a pop frees the head in the same cycle.
module i2s_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         wr_en, rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/i2s_rx_capture.sv
// Records a fixed-length I2S clip from a codec ADC into SDRAM as 128-bit words
// of eight interleaved samples (lane 0 left), starting at BASE_ADDR.
module i2s_rx_capture
    import i2s_pkg::*;
#(
    parameter logic [21:0] BASE_ADDR  = 22'h000000,
    parameter int          NUM_WORDS  = 200,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          Clk50,
    input  logic          reset,
    input  logic          SClk,
    input  logic          LRClk,
    input  logic          Din,
    input  logic          enable,
    input  logic          sdram_Wait,
    input  logic          sdram_ac,
    output logic          sdram_wr,
    output logic [21:0]   sdram_addr,
    output logic [127:0]  sdram_data,
    output logic          busy,
    output logic          done,
    output logic          overrun
);
    localparam int               CNT_W     = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] CNT_LSB   = CNT_W'(SAMPLE_W);
    localparam logic [21:0]      LAST_WORD = 22'(NUM_WORDS - 1);
    localparam logic [3:0]       LANES     = 4'(SAMPLES_PER_WORD);

    logic [2:0]          sclk_s;
    logic [1:0]          lr_s, din_s;
    logic                bit_ev, lr, din, lr_prev, start_ev, shift_en, sample_done;
    logic                en_q, en_rise, push, pop, full, empty;
    logic [CNT_W-1:0]    bit_cnt, cnt_nxt;
    logic [SAMPLE_W-1:0] shreg, sample;
    logic [WORD_W-1:0]   word, head;
    logic [3:0]          lane;
    logic [21:0]         push_cnt, wr_cnt;
    cap_state_t          cap_state;
    wr_state_t           wr_state;

    assign bit_ev   = sclk_s[1] & ~sclk_s[2];
    assign lr       = lr_s[1];
    assign din      = din_s[1];
    assign start_ev = bit_ev & lr_prev & ~lr;
    assign en_rise  = enable & ~en_q;

    always_comb begin
        cnt_nxt = bit_cnt;
        if (lr != lr_prev)        cnt_nxt = '0;
        else if (bit_cnt != CNT_MAX) cnt_nxt = bit_cnt + 1'b1;
    end

    // Count 0 is the previous slot's LSB (one-bit I2S delay); counts 1..16 carry
    // the sample MSB first.
    assign shift_en    = bit_ev && (cnt_nxt != '0) && (cnt_nxt <= CNT_LSB);
    assign sample_done = bit_ev && (cnt_nxt == CNT_LSB);
    assign sample      = {shreg[SAMPLE_W-2:0], din};

    assign push = enable && (cap_state == CAPTURE) && (lane == LANES);
    assign pop  = (wr_state == W_ADV);
    assign busy = (cap_state != IDLE) || !empty || (wr_state != W_IDLE);

    always_ff @(posedge Clk50 or posedge reset) begin
        if (reset) begin
            sclk_s  <= '0;
            lr_s    <= '0;
            din_s   <= '0;
            en_q    <= 1'b0;
            lr_prev <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], SClk};
            lr_s   <= {lr_s[0], LRClk};
            din_s  <= {din_s[0], Din};
            en_q   <= enable;
            if (bit_ev) begin
                lr_prev <= lr;
                bit_cnt <= cnt_nxt;
                if (shift_en) shreg <= sample;
            end
        end
    end

    // Capture starts on a right-to-left transition so lane 0 is always left.
    always_ff @(posedge Clk50 or posedge reset) begin
        if (reset) begin
            cap_state <= IDLE;
            lane      <= '0;
            word      <= '0;
            push_cnt  <= '0;
        end else if (!enable) begin
            cap_state <= IDLE;
            lane      <= '0;
        end else begin
            case (cap_state)
                IDLE: if (en_rise) begin
                    cap_state <= ARM;
                    push_cnt  <= '0;
                end
                ARM: if (start_ev) begin
                    cap_state <= CAPTURE;
                    lane      <= '0;
                end
                CAPTURE: if (lane == LANES) begin
                    lane     <= '0;
                    push_cnt <= push_cnt + 1'b1;
                    if (push_cnt == LAST_WORD) cap_state <= IDLE;
                end else if (sample_done) begin
                    word[{lane[2:0], 4'b0000} +: SAMPLE_W] <= sample;
                    lane <= lane + 1'b1;
                end
                default: cap_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk50 or posedge reset) begin
        if (reset) begin
            wr_state   <= W_IDLE;
            sdram_wr   <= 1'b0;
            sdram_addr <= BASE_ADDR;
            sdram_data <= '0;
            wr_cnt     <= '0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: if (!empty && !sdram_Wait) begin
                    wr_state   <= W_REQ;
                    sdram_wr   <= 1'b1;
                    sdram_data <= head;
                end
                W_REQ: if (sdram_ac) begin
                    wr_state <= W_ADV;
                    sdram_wr <= 1'b0;
                end
                W_ADV: begin
                    wr_state   <= W_IDLE;
                    sdram_addr <= sdram_addr + 1'b1;
                    wr_cnt     <= wr_cnt + 1'b1;
                    if (wr_cnt == LAST_WORD) done <= 1'b1;
                end
                default: wr_state <= W_IDLE;
            endcase
            if (push && full && !pop) overrun <= 1'b1;
            if (en_rise) begin
                sdram_addr <= BASE_ADDR;
                wr_cnt     <= '0;
                done       <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

    i2s_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
        .clk   (Clk50),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata (word),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_i2s_rx_capture.sv
// Bench for i2s_rx_capture: codec model, SDRAM controller model with random
// acknowledge delay, and a write monitor checked against packed sample frames.
module tb_i2s_rx_capture;
    localparam logic [21:0] BASE = 22'h2ABCD;

    logic          Clk50, reset, SClk, LRClk, Din, enable, sdram_Wait;
    logic          sdram_ac = 1'b0;
    logic          sdram_wr, busy, done, overrun;
    logic [21:0]   sdram_addr;
    logic [127:0]  sdram_data;

    int            n_chk = 0, n_err = 0, n_wr = 0;
    logic [127:0]  exp_q[$];
    logic [127:0]  wr_log[$];
    logic [15:0]   fl[0:31], fr[0:31];
    bit            rand_wait = 0, hold_ac = 0;

    i2s_rx_capture #(.BASE_ADDR(BASE), .NUM_WORDS(6), .FIFO_DEPTH(4)) dut (
        .Clk50(Clk50), .reset(reset), .SClk(SClk), .LRClk(LRClk), .Din(Din),
        .enable(enable), .sdram_Wait(sdram_Wait), .sdram_ac(sdram_ac),
        .sdram_wr(sdram_wr), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
        .busy(busy), .done(done), .overrun(overrun)
    );

    initial begin
        Clk50 = 1'b0;
        forever #5 Clk50 = ~Clk50;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk50);
        #1;
    endtask

    // One 32-bit slot: bit 0 is the previous slot's LSB, bits 1..16 the sample.
    task automatic send_slot(input logic lr, input logic [15:0] s, input int en_mid);
        for (int i = 0; i < 32; i++) begin
            SClk  = 1'b0;
            LRClk = lr;
            Din   = (i >= 1 && i <= 16) ? s[16-i] : 1'($urandom_range(0, 1));
            if (i == 20 && en_mid >= 0) enable = en_mid[0];
            tick(4);
            SClk = 1'b1;
            tick(4);
        end
    endtask

    task automatic send_frame(input int f, input int en_l, input int en_r);
        if (rand_wait) sdram_Wait = ($urandom_range(0, 9) < 3);
        send_slot(1'b0, fl[f], en_l);
        if (rand_wait) sdram_Wait = ($urandom_range(0, 9) < 3);
        send_slot(1'b1, fr[f], en_r);
    endtask

    // Four consecutive L/R frames form one word, lane 2i = left, 2i+1 = right.
    function automatic logic [127:0] pack(input int f0);
        logic [127:0] w;
        for (int i = 0; i < 4; i++) begin
            w[32*i +: 16]    = fl[f0+i];
            w[32*i+16 +: 16] = fr[f0+i];
        end
        return w;
    endfunction

    task automatic new_frames();
        for (int f = 0; f < 32; f++) begin
            fl[f] = 16'($urandom);
            fr[f] = 16'($urandom);
        end
    endtask

    task automatic clear_log();
        exp_q.delete();
        wr_log.delete();
        n_wr = 0;
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (n_wr < n && t < 4000) begin
            tick(1);
            t++;
        end
        chk("write_count", 128'(n_wr), 128'(n));
    endtask

    // SDRAM controller: acknowledges each request after a random 0..10 cycle delay.
    initial begin
        int ack_cnt = 0;
        int ac_delay = 10;
        forever begin
            @(posedge Clk50);
            #1;
            if (reset) begin
                sdram_ac = 1'b0;
                ack_cnt  = 0;
            end else if (sdram_ac) begin
                sdram_ac = 1'b0;
            end else if (sdram_wr && !hold_ac) begin
                if (ack_cnt >= ac_delay) begin
                    sdram_ac = 1'b1;
                    ack_cnt  = 0;
                    ac_delay = $urandom_range(0, 10);
                end else begin
                    ack_cnt++;
                end
            end
        end
    end

    // Write monitor: request rules, hold stability, and each accepted write.
    initial begin
        logic         wr_q = 1'b0, wait_q = 1'b0;
        logic [21:0]  addr_q = '0;
        logic [127:0] data_q = '0;
        forever begin
            @(negedge Clk50);
            if (reset) begin
                wr_q = 1'b0;
            end else begin
                if (sdram_wr && wr_q) begin
                    chk("wr_data_stable", sdram_data, data_q);
                    chk("wr_addr_stable", 128'(sdram_addr), 128'(addr_q));
                end
                if (sdram_wr && !wr_q) chk("req_during_wait", 128'(wait_q), 128'(0));
                if (sdram_wr && sdram_ac) begin
                    if (n_wr < exp_q.size()) begin
                        chk("wr_addr", 128'(sdram_addr), 128'(22'(BASE + n_wr)));
                        chk("wr_data", sdram_data, exp_q[n_wr]);
                    end else begin
                        chk("extra_write", 128'(n_wr + 1), 128'(exp_q.size()));
                    end
                    wr_log.push_back(sdram_data);
                    n_wr++;
                end
                wr_q   = sdram_wr;
                data_q = sdram_data;
                addr_q = sdram_addr;
            end
            wait_q = sdram_Wait;
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; SClk = 1'b0; LRClk = 1'b0; Din = 1'b0; sdram_Wait = 1'b0;
        tick(3);
        chk("rst_wr", 128'(sdram_wr), 128'(0));
        chk("rst_addr", 128'(sdram_addr), 128'(22'h2ABCD));
        chk("rst_data", sdram_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_overrun", 128'(overrun), 128'(0));
        reset = 1'b0;
        tick(2);

        // Recording A: enable mid left slot, random Wait, 6 words then stop.
        new_frames();
        for (int f = 1; f <= 4; f++) begin
            fl[f] = 16'h1234;
            fr[f] = 16'hABCD;
        end
        clear_log();
        for (int j = 0; j < 6; j++) exp_q.push_back(pack(1 + 4*j));
        rand_wait = 1;
        send_frame(0, 1, -1);
        for (int f = 1; f <= 26; f++) send_frame(f, -1, -1);
        rand_wait = 0;
        sdram_Wait = 1'b0;
        wait_writes(6);
        tick(3);
        chk("A_first_word", wr_log[0], 128'hABCD1234_ABCD1234_ABCD1234_ABCD1234);
        chk("A_done", 128'(done), 128'(1));
        chk("A_overrun", 128'(overrun), 128'(0));
        chk("A_busy", 128'(busy), 128'(0));
        chk("A_next_addr", 128'(sdram_addr), 128'(22'h2ABD3));

        // Recording B: enable mid right slot, Wait held through 5 pushes.
        enable = 1'b0;
        tick(20);
        new_frames();
        fl[0] = 16'hDEAD; fr[0] = 16'hBEEF; fl[1] = 16'h5A5A;
        clear_log();
        for (int j = 0; j < 6; j++) if (j != 4) exp_q.push_back(pack(1 + 4*j));
        sdram_Wait = 1'b1;
        send_frame(0, -1, 1);
        chk("B_addr_reload", 128'(sdram_addr), 128'(22'h2ABCD));
        chk("B_done_clear", 128'(done), 128'(0));
        for (int f = 1; f <= 21; f++) send_frame(f, -1, -1);
        chk("B_overrun_set", 128'(overrun), 128'(1));
        chk("B_no_write_yet", 128'(n_wr), 128'(0));
        sdram_Wait = 1'b0;
        for (int f = 22; f <= 26; f++) send_frame(f, -1, -1);
        wait_writes(5);
        tick(3);
        chk("B_lane0_left", 128'(wr_log[0][15:0]), 128'(16'h5A5A));
        chk("B_done", 128'(done), 128'(0));
        chk("B_overrun", 128'(overrun), 128'(1));
        chk("B_busy", 128'(busy), 128'(0));
        chk("B_next_addr", 128'(sdram_addr), 128'(22'h2ABD2));

        // Recording C: reset while a request is held unacknowledged.
        enable = 1'b0;
        tick(20);
        new_frames();
        clear_log();
        exp_q.push_back(pack(1));
        hold_ac = 1;
        send_frame(0, 1, -1);
        chk("C_overrun_clear", 128'(overrun), 128'(0));
        for (int f = 1; f <= 5; f++) send_frame(f, -1, -1);
        chk("C_req_up", 128'(sdram_wr), 128'(1));
        reset = 1'b1;
        #1;
        chk("C_rst_wr", 128'(sdram_wr), 128'(0));
        chk("C_rst_addr", 128'(sdram_addr), 128'(22'h2ABCD));
        chk("C_rst_busy", 128'(busy), 128'(0));
        tick(1);
        chk("C_rst_wr_edge", 128'(sdram_wr), 128'(0));
        chk("C_rst_done", 128'(done), 128'(0));
        chk("C_rst_overrun", 128'(overrun), 128'(0));
        enable = 1'b0;
        hold_ac = 0;
        reset = 1'b0;
        tick(5);
        chk("C_idle_after", 128'(busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
